// File: rtl/encoder_8_3_seq.sv
// 8-to-3 priority encoder (active-low request lines) feeding a small output FIFO.
// Optional one-hot checking with sticky err is enabled by defining ENCODER_ONEHOT_CHECK_EN.
module encoder_8_3_seq #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] enc_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] enc_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    input  logic       err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    logic [2:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    low;
    logic [2:0]    prio_code;
    logic          accept;
    logic          pop;
    logic          push;

    assign low = ~enc_in;

    // Scanning downward lets the lowest asserted line overwrite the result last.
    always_comb begin
        prio_code = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (low[k]) prio_code = 3'(7 - k);
        end
    end

    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign enc_out   = out_valid ? mem[rd_ptr] : 3'd0;
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

`ifdef ENCODER_ONEHOT_CHECK_EN
    logic none_low;
    logic multi_low;
    logic err_event;
    logic err_q;

    assign none_low  = (low == 8'd0);
    assign multi_low = ((low & (low - 8'd1)) != 8'd0);
    assign push      = accept && !none_low;
    assign err_event = accept && (none_low || multi_low);
    assign err       = err_q;

    // A fresh error takes priority over a clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_event) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end
`else
    logic unused_err_clr;

    assign push           = accept;
    assign err            = 1'b0;
    assign unused_err_clr = err_clr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: enc_out is forced to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= prio_code;
    end

endmodule

// File: tb/tb_encoder_8_3_seq.sv
// Self-checking bench for encoder_8_3_seq: directed scenarios then random traffic
// compared against a queue-based reference model.
module tb_encoder_8_3_seq;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] enc_in;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] enc_out;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic       err_clr;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int m_q[$];
    bit m_err = 1'b0;

    encoder_8_3_seq #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enc_in    (enc_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .enc_out   (enc_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    function automatic int count_low(input logic [7:0] v);
        int n = 0;
        for (int k = 0; k < 8; k++) if (v[k] == 1'b0) n++;
        return n;
    endfunction

    // Lowest-index low line wins and maps to code 7-k; no low line gives 0.
    function automatic int ref_code(input logic [7:0] v);
        for (int k = 0; k < 8; k++) if (v[k] == 1'b0) return 7 - k;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        assert (actual === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".in_ready"},  8'(in_ready),  8'(m_q.size() < DEPTH));
        chk({tag, ".out_valid"}, 8'(out_valid), 8'(m_q.size() > 0));
        chk({tag, ".enc_out"},   8'(enc_out),   (m_q.size() > 0) ? 8'(m_q[0]) : 8'd0);
        chk({tag, ".err"},       8'(err),       8'(m_err));
    endtask

    // Drives one cycle of inputs, advances the model across the edge, returns #1 after it.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic c);
        bit acc;
        bit pp;
        int n;
        in_valid  = v;
        enc_in    = d;
        out_ready = r;
        err_clr   = c;
        acc = v && (m_q.size() < DEPTH);
        pp  = r && (m_q.size() > 0);
        n   = count_low(d);
        @(posedge clk);
        if (pp) void'(m_q.pop_front());
`ifdef ENCODER_ONEHOT_CHECK_EN
        if (c) m_err = 1'b0;
        if (acc && n != 1) m_err = 1'b1;
        if (acc && n > 0) m_q.push_back(ref_code(d));
`else
        if (acc) m_q.push_back(ref_code(d));
`endif
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        enc_in    = 8'hFF;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        #1;
        chk("reset.out_valid", 8'(out_valid), 8'd0);
        chk("reset.enc_out",   8'(enc_out),   8'd0);
        chk("reset.err",       8'(err),       8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset");

        applyStimulus(1'b1, 8'hFE, 1'b1, 1'b0);
        checkOutput("single");
        chk("single.code7", 8'(enc_out), 8'd7);
        applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0);
        checkOutput("single_pop");
        chk("single_pop.empty", 8'(out_valid), 8'd0);

        applyStimulus(1'b1, 8'hFB, 1'b0, 1'b0);
        checkOutput("fill1");
        applyStimulus(1'b1, 8'hBF, 1'b0, 1'b0);
        checkOutput("fill2");
        chk("full.in_ready", 8'(in_ready), 8'd0);
        chk("full.code5",    8'(enc_out),  8'd5);
        applyStimulus(1'b1, 8'hFE, 1'b0, 1'b0);
        checkOutput("full_hold");
        chk("full_hold.code5", 8'(enc_out), 8'd5);
        applyStimulus(1'b1, 8'hFE, 1'b1, 1'b0);
        checkOutput("full_pop");
        chk("full_pop.in_ready", 8'(in_ready), 8'd1);
        chk("full_pop.code1",    8'(enc_out),  8'd1);
        applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0);
        checkOutput("drain");

        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("none_low");
`ifdef ENCODER_ONEHOT_CHECK_EN
        chk("none_low.err",   8'(err),       8'd1);
        chk("none_low.empty", 8'(out_valid), 8'd0);
`else
        chk("none_low.err",  8'(err),       8'd0);
        chk("none_low.push", 8'(out_valid), 8'd1);
`endif
        applyStimulus(1'b1, 8'hF0, 1'b0, 1'b0);
        checkOutput("multi_low");
        applyStimulus(1'b0, 8'hFF, 1'b1, 1'b1);
        checkOutput("err_clr");
        chk("err_clr.err", 8'(err), 8'd0);
        applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0);
        checkOutput("drain2");
        applyStimulus(1'b0, 8'hFF, 1'b1, 1'b0);
        checkOutput("drain3");

        applyStimulus(1'b1, 8'hFD, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hDF, 1'b0, 1'b0);
        checkOutput("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset.out_valid", 8'(out_valid), 8'd0);
        chk("mid_reset.enc_out",   8'(enc_out),   8'd0);
        chk("mid_reset.err",       8'(err),       8'd0);
        m_q.delete();
        m_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("after_reset");
        chk("after_reset.in_ready", 8'(in_ready), 8'd1);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            int mode = $urandom_range(0, 7);
            if (mode < 4)       d = ~(8'd1 << $urandom_range(0, 7));
            else if (mode == 4) d = 8'hFF;
            else                d = 8'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), d,
                          ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
            checkOutput("random");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/encoder_8_3_seq.md
ENCODER_8_3_SEQ -- requirements
Module: encoder_8_3_seq

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, output buffer entries; the block SHALL support the power-of-two values 2, 4 and 8.
REQ-002 Port: clk  input  1  sole clock; all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: enc_in  input  8  active-low one-hot request lines; line k low requests code 7-k, the inverse of the team's 3-to-8 NAND decoder mapping.
REQ-005 Port: in_valid  input  1  enc_in qualifier.
REQ-006 Port: in_ready  output  1  block can accept; high when buffer not full.
REQ-007 Port: enc_out  output  3  encoded code at buffer head.
REQ-008 Port: out_valid  output  1  enc_out qualifier; high when buffer not empty.
REQ-009 Port: out_ready  input  1  consumer accepts enc_out.
REQ-010 Port: err  output  1  sticky encoding-error flag.
REQ-011 Port: err_clr  input  1  synchronous clear of err.

Function
REQ-012 Accept SHALL occur on a clk edge with in_valid && in_ready; pop SHALL occur on a clk edge with out_valid && out_ready.
REQ-013 Encoding: the lowest index k with enc_in[k]==0 SHALL win; code = 7-k (enc_in=8'b1111_1110 -> 3'd7, 8'b0111_1111 -> 3'd0).
REQ-014 Accepted codes SHALL be buffered FIFO-order, FIFO_DEPTH entries, head presented combinationally on enc_out.
REQ-015 Latency: accept into empty buffer SHALL give out_valid=1 with that code on the next cycle; no combinational in_valid->out_valid path.
REQ-016 in_ready SHALL depend only on registered occupancy (no out_ready->in_ready path); when full, in_ready=0 even if a pop occurs that cycle.
REQ-017 Simultaneous accept and pop when neither empty nor full SHALL leave occupancy unchanged and preserve order.
REQ-018 Pop when empty and accept when full are impossible by REQ-012 and SHALL not alter state.
REQ-019 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-020 enc_out SHALL hold its value while out_valid && !out_ready; when empty, enc_out SHALL be 3'd0.
REQ-021 err_clr SHALL clear err; an error event in the same cycle as err_clr SHALL win (err=1).

Reset
REQ-022 rst_n low SHALL immediately force: buffer empty, out_valid=0, enc_out=0, err=0; in_ready SHALL be 1 on the first edge after deassertion.
REQ-023 Reset mid-transfer SHALL discard all buffered codes; no stale code SHALL appear after reset.

Configuration
REQ-024 Macro ENCODER_ONEHOT_CHECK_EN defined: on accept, zero low lines SHALL set err and the entry SHALL be dropped (not pushed); two or more low lines SHALL set err and the priority code SHALL still be pushed.
REQ-025 Macro undefined: err SHALL be tied 0, err_clr ignored; zero low lines SHALL push code 3'd0; multiple low lines SHALL push the priority code.

Verification
REQ-026 Reset, then accept enc_in=8'hFE, out_ready=1 -> next cycle out_valid=1, enc_out=7; popped, out_valid=0 after.
REQ-027 out_ready=0, accept 8'hFB, 8'hBF with FIFO_DEPTH=2 -> in_ready=0 after second; enc_out=5 stable; release out_ready -> 5 then 1, in_ready returns 1.
REQ-028 Full buffer, in_valid=1, out_ready=1 same cycle -> pop only, occupancy 1, no accept that cycle.
REQ-029 With ENCODER_ONEHOT_CHECK_EN: accept 8'hFF -> err=1, nothing pushed; accept 8'hF0 -> code 7 pushed, err stays 1; err_clr -> err=0.
REQ-030 Without macro: accept 8'hFF -> enc_out=0 pushed, err=0.
REQ-031 rst_n low for one cycle with two codes buffered -> out_valid=0 immediately, enc_out=0, err=0, in_ready=1 after release.
